// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM line/word controller.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int READ_BEATS  = 4;
    localparam int WRITE_BEATS = 2;

    localparam logic [1:0] READ_LAST_BEAT  = 2'(READ_BEATS - 1);
    localparam logic [1:0] WRITE_LAST_BEAT = 2'(WRITE_BEATS - 1);

endpackage

// File: rtl/sram_beat_timer.sv
// Per-beat wait timer: down-counts ACCESS_CYCLES while active and flags the
// last cycle of each beat. Idles at zero, where zero means "fresh beat".
module sram_beat_timer #(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic beat_last
);

    localparam logic [3:0] CYCLES = 4'(ACCESS_CYCLES);

    logic [3:0] cnt;
    logic [3:0] remaining;

    assign remaining = (cnt == 4'd0) ? CYCLES : cnt;
    assign beat_last = active && (remaining == 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (!active || beat_last) begin
            cnt <= 4'd0;
        end else begin
            cnt <= remaining - 4'd1;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Bridges cache-side 64-bit line reads and 32-bit word writes onto a 16-bit
// external SRAM, one halfword beat per ACCESS_CYCLES clocks.
//
//   state | meaning
//   IDLE  | waiting for a request; bus parked
//   READ  | four read beats, capturing one halfword per beat
//   WRITE | two write beats, low halfword then high halfword
//   DONE  | one-cycle completion, ready asserted
import sram_pkg::*;

module sram_controller #(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        sram_read,
    input  logic        sram_write,
    output logic [63:0] rdata,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_OUT,
    input  logic [15:0] SRAM_DQ_IN,
    output logic        SRAM_DQ_OE,
    output logic        SRAM_WE_N
);

    state_t      state;
    logic [1:0]  beat;
    logic [17:0] base;
    logic [31:0] wdata_q;
    logic        beat_last;
    logic [1:0]  beat_next;
    logic        unused_bits;

    // Low write halfword is driven straight from wdata on entry to WRITE.
    assign unused_bits = ^{address[31:19], address[0], wdata_q[15:0]};
    assign beat_next   = beat + 2'd1;

    assign ready = ((state == IDLE) && !sram_read && !sram_write) || (state == DONE);

    sram_beat_timer #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_beat_timer (
        .clk      (clk),
        .rst      (rst),
        .active   ((state == READ) || (state == WRITE)),
        .beat_last(beat_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            beat        <= 2'd0;
            base        <= 18'd0;
            wdata_q     <= 32'd0;
            rdata       <= 64'd0;
            SRAM_ADDR   <= 18'd0;
            SRAM_DQ_OUT <= 16'd0;
            SRAM_DQ_OE  <= 1'b0;
            SRAM_WE_N   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    beat <= 2'd0;
                    if (sram_write) begin
                        state       <= WRITE;
                        base        <= {address[18:2], 1'b0};
                        wdata_q     <= wdata;
                        SRAM_ADDR   <= {address[18:2], 1'b0};
                        SRAM_DQ_OUT <= wdata[15:0];
                        SRAM_DQ_OE  <= 1'b1;
                        SRAM_WE_N   <= 1'b0;
                    end else if (sram_read) begin
                        state       <= READ;
                        base        <= {address[18:3], 2'b00};
                        SRAM_ADDR   <= {address[18:3], 2'b00};
                        SRAM_DQ_OUT <= 16'd0;
                        SRAM_DQ_OE  <= 1'b0;
                        SRAM_WE_N   <= 1'b1;
                    end else begin
                        SRAM_ADDR   <= 18'd0;
                        SRAM_DQ_OUT <= 16'd0;
                        SRAM_DQ_OE  <= 1'b0;
                        SRAM_WE_N   <= 1'b1;
                    end
                end
                READ: begin
                    if (beat_last) begin
                        rdata[16*beat +: 16] <= SRAM_DQ_IN;
                        if (beat == READ_LAST_BEAT) begin
                            state     <= DONE;
                            beat      <= 2'd0;
                            SRAM_ADDR <= 18'd0;
                        end else begin
                            beat      <= beat_next;
                            SRAM_ADDR <= base | 18'(beat_next);
                        end
                    end
                end
                WRITE: begin
                    if (beat_last) begin
                        if (beat == WRITE_LAST_BEAT) begin
                            state       <= DONE;
                            beat        <= 2'd0;
                            SRAM_ADDR   <= 18'd0;
                            SRAM_DQ_OUT <= 16'd0;
                            SRAM_DQ_OE  <= 1'b0;
                            SRAM_WE_N   <= 1'b1;
                        end else begin
                            beat        <= beat_next;
                            SRAM_ADDR   <= base | 18'(beat_next);
                            SRAM_DQ_OUT <= wdata_q[31:16];
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    beat        <= 2'd0;
                    SRAM_ADDR   <= 18'd0;
                    SRAM_DQ_OUT <= 16'd0;
                    SRAM_DQ_OE  <= 1'b0;
                    SRAM_WE_N   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (ACCESS_CYCLES 1 and 3), each with
// a small SRAM model, checked against a transaction-level reference.
module tb_sram_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] address    [2];
    logic [31:0] wdata      [2];
    logic        sram_read  [2];
    logic        sram_write [2];
    logic [63:0] rdata      [2];
    logic        ready      [2];
    logic [17:0] sram_addr  [2];
    logic [15:0] dq_out     [2];
    logic [15:0] dq_in      [2];
    logic        dq_oe      [2];
    logic        we_n       [2];

    sram_controller #(.ACCESS_CYCLES(1)) u_dut_ac1 (
        .clk(clk), .rst(rst), .address(address[0]), .wdata(wdata[0]),
        .sram_read(sram_read[0]), .sram_write(sram_write[0]), .rdata(rdata[0]),
        .ready(ready[0]), .SRAM_ADDR(sram_addr[0]), .SRAM_DQ_OUT(dq_out[0]),
        .SRAM_DQ_IN(dq_in[0]), .SRAM_DQ_OE(dq_oe[0]), .SRAM_WE_N(we_n[0])
    );

    sram_controller #(.ACCESS_CYCLES(3)) u_dut_ac3 (
        .clk(clk), .rst(rst), .address(address[1]), .wdata(wdata[1]),
        .sram_read(sram_read[1]), .sram_write(sram_write[1]), .rdata(rdata[1]),
        .ready(ready[1]), .SRAM_ADDR(sram_addr[1]), .SRAM_DQ_OUT(dq_out[1]),
        .SRAM_DQ_IN(dq_in[1]), .SRAM_DQ_OE(dq_oe[1]), .SRAM_WE_N(we_n[1])
    );

    // External SRAM models (64 halfwords each, aliased on low address bits)
    logic [15:0] mem     [2][64];
    logic [15:0] ref_mem [2][64];
    logic [63:0] last_rd [2];
    logic        pre_en;
    int          pre_i;
    logic [5:0]  pre_a;
    logic [15:0] pre_d;

    always @(posedge clk) begin
        if (pre_en) mem[pre_i][pre_a] <= pre_d;
        for (int i = 0; i < 2; i++)
            if (!we_n[i]) mem[i][sram_addr[i][5:0]] <= dq_out[i];
    end

    always_comb begin
        for (int i = 0; i < 2; i++) dq_in[i] = mem[i][sram_addr[i][5:0]];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ac_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic preload(input int i, input logic [5:0] a, input logic [15:0] d);
        pre_en = 1'b1; pre_i = i; pre_a = a; pre_d = d;
        ref_mem[i][a] = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic check_parked(input int i, input string tag);
        chk({tag, "_addr"}, 64'(sram_addr[i]), 64'd0);
        chk({tag, "_we_n"}, 64'(we_n[i]), 64'd1);
        chk({tag, "_oe"}, 64'(dq_oe[i]), 64'd0);
    endtask

    // One transaction on instance i, started in the cycle after the call.
    task automatic do_txn(input int i, input bit wr, input bit rd,
                          input logic [31:0] addr, input logic [31:0] data);
        int          ac, lat, n, k;
        bit          done;
        logic [17:0] base;
        logic [63:0] exp_line;
        ac   = ac_of(i);
        lat  = (wr ? 2 : 4) * ac + 1;
        base = wr ? (addr[18:1] & ~18'd1) : (addr[18:1] & ~18'd3);
        @(negedge clk);
        address[i] = addr; wdata[i] = data;
        sram_write[i] = wr; sram_read[i] = rd;
        #1;
        chk("ready_drop", 64'(ready[i]), 64'd0);
        n = 0; done = 0;
        while (!done && n < lat + 5) begin
            @(negedge clk);
            n++;
            if (ready[i]) begin
                done = 1;
            end else if (n < lat) begin
                k = (n - 1) / ac;
                chk("beat_addr", 64'(sram_addr[i]), 64'(base + 18'(k)));
                chk("beat_we_n", 64'(we_n[i]), 64'(!wr));
                chk("beat_oe", 64'(dq_oe[i]), 64'(wr));
                if (wr) chk("beat_dq", 64'(dq_out[i]), 64'(k ? data[31:16] : data[15:0]));
            end
        end
        sram_write[i] = 1'b0; sram_read[i] = 1'b0;
        chk(wr ? "wr_latency" : "rd_latency", 64'(n), 64'(lat));
        check_parked(i, "done");
        if (wr) begin
            ref_mem[i][base[5:0]]       = data[15:0];
            ref_mem[i][base[5:0] + 6'd1] = data[31:16];
            chk("mem_lo", 64'(mem[i][base[5:0]]), 64'(ref_mem[i][base[5:0]]));
            chk("mem_hi", 64'(mem[i][base[5:0] + 6'd1]), 64'(ref_mem[i][base[5:0] + 6'd1]));
            chk("rdata_hold", rdata[i], last_rd[i]);
        end else begin
            for (int b = 0; b < 4; b++)
                exp_line[16*b +: 16] = ref_mem[i][base[5:0] + 6'(b)];
            chk("rdata", rdata[i], exp_line);
            last_rd[i] = exp_line;
        end
    endtask

    task automatic reset_mid_read(input int i, input logic [31:0] addr);
        int ac;
        ac = ac_of(i);
        @(negedge clk);
        address[i] = addr; sram_read[i] = 1'b1;
        repeat (1 + 2 * ac) @(negedge clk);
        chk("rst_in_beat2", 64'(sram_addr[i]), 64'((addr[18:1] & ~18'd3) + 18'd2));
        rst = 1'b1; sram_read[i] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 64'(ready[i]), 64'd1);
        chk("rst_rdata", rdata[i], 64'd0);
        chk("rst_dq_out", 64'(dq_out[i]), 64'd0);
        check_parked(i, "rst");
        last_rd[i] = 64'd0;
    endtask

    initial begin
        rst = 1'b1; pre_en = 1'b0; pre_i = 0; pre_a = '0; pre_d = '0;
        for (int i = 0; i < 2; i++) begin
            address[i] = '0; wdata[i] = '0; sram_read[i] = 0; sram_write[i] = 0;
            last_rd[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("in_reset_ready", 64'(ready[0]), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("post_reset_ready", 64'(ready[i]), 64'd1);
            chk("post_reset_rdata", rdata[i], 64'd0);
            chk("post_reset_dq", 64'(dq_out[i]), 64'd0);
            check_parked(i, "post_reset");
        end

        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 64; a++) preload(i, 6'(a), 16'($urandom));

        // Directed: line read at 0x108 -> halfwords 0x84..0x87
        for (int i = 0; i < 2; i++) begin
            preload(i, 6'h04, 16'h1111); preload(i, 6'h05, 16'h2222);
            preload(i, 6'h06, 16'h3333); preload(i, 6'h07, 16'h4444);
        end
        do_txn(0, 0, 1, 32'h0000_0108, 32'h0);
        chk("rdata_0108", rdata[0], 64'h4444_3333_2222_1111);
        do_txn(0, 1, 0, 32'h0000_0204, 32'hDEAD_BEEF);
        do_txn(0, 0, 1, 32'h0000_0204, 32'h0);
        do_txn(0, 1, 1, 32'h0000_0108, 32'h1234_5678);
        do_txn(1, 0, 1, 32'h0000_0108, 32'h0);
        chk("rdata_0108_ac3", rdata[1], 64'h4444_3333_2222_1111);
        do_txn(1, 1, 1, 32'hFFFF_FFFF, 32'hCAFE_F00D);

        reset_mid_read(0, 32'h0000_0108);
        do_txn(0, 0, 1, 32'h0000_0108, 32'h0);
        reset_mid_read(1, 32'h0000_0010);
        do_txn(1, 0, 1, 32'h0000_0010, 32'h0);

        for (int t = 0; t < 40; t++) begin
            int  i, kind;
            i    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 2));
            do_txn(i, kind != 0, kind != 1, $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 1; clock cycles each 16-bit SRAM beat is held (legal 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port address, input, 32, byte address from the cache side; bits [18:1] are used.
REQ-005 SHALL have port wdata, input, 32, write data from the cache side.
REQ-006 SHALL have port sram_read, input, 1, 64-bit line read request; held until ready.
REQ-007 SHALL have port sram_write, input, 1, 32-bit word write request; held until ready.
REQ-008 SHALL have port rdata, output, 64, assembled line; halfword k at [16k+15:16k].
REQ-009 SHALL have port ready, output, 1, high when no transfer is pending or the transfer completes.
REQ-010 SHALL have port SRAM_ADDR, output, 18, external halfword address.
REQ-011 SHALL have port SRAM_DQ_OUT, output, 16, write data to the external SRAM.
REQ-012 SHALL have port SRAM_DQ_IN, input, 16, read data from the external SRAM.
REQ-013 SHALL have port SRAM_DQ_OE, output, 1, drives the DQ pins when high.
REQ-014 SHALL have port SRAM_WE_N, output, 1, active-low write strobe.

Function
REQ-015 SHALL implement states IDLE, READ, WRITE and DONE.
REQ-016 In IDLE with sram_write high, SHALL latch base = {address[18:2],1'b0} and wdata, then enter WRITE; sram_write SHALL take priority over sram_read.
REQ-017 In IDLE with only sram_read high, SHALL latch base = {address[18:3],2'b00}, then enter READ.
REQ-018 READ SHALL run 4 beats (k = 0..3), each lasting ACCESS_CYCLES cycles with SRAM_ADDR = base+k, SRAM_WE_N=1 and SRAM_DQ_OE=0.
REQ-019 SHALL capture SRAM_DQ_IN into rdata slice k on the last cycle of beat k.
REQ-020 WRITE SHALL run 2 beats; beat 0 drives wdata[15:0] at base and beat 1 drives wdata[31:16] at base+1; SRAM_WE_N=0 and SRAM_DQ_OE=1 throughout each beat.
REQ-021 After the last beat, SHALL enter DONE for exactly one cycle, then return to IDLE unconditionally.
REQ-022 ready SHALL be combinational: (IDLE and neither request) or DONE; it SHALL drop in the same cycle a request appears in IDLE.
REQ-023 Read latency SHALL be 4*ACCESS_CYCLES+1 cycles from the request cycle to the ready cycle; write latency SHALL be 2*ACCESS_CYCLES+1 cycles.
REQ-024 rdata SHALL hold its value from DONE until the next read's first capture.
REQ-025 Request deassertion mid-transfer SHALL be ignored; a started transfer always completes.
REQ-026 Beat and wait counters SHALL wrap only via state exit; SRAM_ADDR = base+k SHALL never carry beyond the aligned group.
REQ-027 In IDLE and DONE, SHALL drive SRAM_WE_N=1, SRAM_DQ_OE=0 and SRAM_ADDR=0.

Reset
REQ-028 rst high at a clock edge SHALL force IDLE, clear both counters, and clear rdata and the latched base/wdata to 0, including mid-transfer.
REQ-029 During and after reset, SHALL drive SRAM_WE_N=1, SRAM_DQ_OE=0, SRAM_ADDR=0 and SRAM_DQ_OUT=0; ready SHALL be 1 unless a request is present.

Structure
REQ-030 The state encoding, READ_BEATS=4 and WRITE_BEATS=2 SHALL live in the shared package sram_pkg.
REQ-031 SHALL instantiate one sub-module, sram_beat_timer, which counts ACCESS_CYCLES per beat and flags the last cycle of a beat.
REQ-032 The external DQ tristate SHALL sit outside this block, at top level.

Verification
REQ-033 Read test: ACCESS_CYCLES=1, read 0x0000_0108 with the SRAM model returning 0x1111/0x2222/0x3333/0x4444 at addresses 0x84..0x87 -> ready high 5 cycles later and rdata=0x4444_3333_2222_1111.
REQ-034 Write test: write 0xDEAD_BEEF to 0x0000_0204 -> SRAM_WE_N low on 0x102 (0xBEEF) then on 0x103 (0xDEAD); ready high 3 cycles after the request.
REQ-035 Priority test: read and write asserted together -> WRITE sequence only, with no SRAM_ADDR read beats.
REQ-036 Timing test: ACCESS_CYCLES=3 read -> each address held for 3 cycles; ready 13 cycles after the request.
REQ-037 Reset test: rst asserted during read beat 2 -> next cycle IDLE, SRAM_WE_N=1, rdata=0; a fresh read then completes correctly.
REQ-038 Back-to-back test: write followed by a read presented the cycle after DONE -> ready drops immediately and the read completes with the correct data.
